// File: rtl/pool_nl_pkg.sv
// Shared definitions for the pool_nl datapath: stage flag bundle, width helper
// and the default PE-array geometry.
package pool_nl_pkg;

  // Default PE-array geometry, shared with the PE array outputs.
  localparam int N_PE        = 32;
  localparam int WID_PE_BITS = 16;

  // Control flags carried alongside each pipeline stage.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_flags_t;

  // Ceiling log2 for width derivation; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered pairwise-reduction level of the adder tree. Reduces N_IN
// signed values of width IN_W to N_IN/2 sign-extended sums of width IN_W+1.
// Flags ride along with the data; the whole stage holds when adv=0.
module adder_tree_stage
  import pool_nl_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int IN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adv,
  input  stage_flags_t           flags_in,
  input  logic signed [IN_W-1:0] data_in  [N_IN-1:0],
  output stage_flags_t           flags_out,
  output logic signed [IN_W:0]   data_out [N_IN/2-1:0]
);

  // Register pairwise sums and flags whenever the pipeline advances.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      flags_out <= '0;
      // NOTE: the sum registers are cleared explicitly; a partial group must
      // leave no residue in the data path after reset.
      for (int i = 0; i < N_IN / 2; i++) begin
        data_out[i] <= '0;
      end
    end else if (adv) begin
      flags_out <= flags_in;
      for (int i = 0; i < N_IN / 2; i++) begin
        data_out[i] <= {data_in[2*i][IN_W-1], data_in[2*i]}
                     + {data_in[2*i+1][IN_W-1], data_in[2*i+1]};
      end
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed reduction tree with per-lane masking, valid/ready flow
// control and multi-beat accumulation. Reduces N_IN lanes per beat through
// S = clog2(N_IN) registered stages, then an accumulator/output stage.
// Optional build macro ADDER_TREE_SAT_EN: clamp the result to OUT_W and flag
// clamping on out_sat; without it the result wraps and out_sat is tied 0.
module adder_tree_acc
  import pool_nl_pkg::*;
#(
  parameter int N_IN  = N_PE,
  parameter int IN_W  = WID_PE_BITS,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data [N_IN-1:0],
  input  logic [N_IN-1:0]         lane_en,
  input  logic                    acc_mode,
  input  logic [CNT_W-1:0]        acc_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int S     = clog2(N_IN);
  localparam int SUM_W = IN_W + S;
  localparam int ACC_W = SUM_W + CNT_W;

  logic                    adv;
  logic                    accept;
  logic signed [IN_W-1:0]  lane [N_IN-1:0];
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        len_q;
  logic                    mode_q;
  logic                    beat_first;
  logic                    beat_last;
  logic                    eff_mode;
  logic [CNT_W-1:0]        eff_len;
  stage_flags_t            head_flags;
  stage_flags_t            tail_flags;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] acc;

  // A stalled result freezes the whole pipe and blocks the input that cycle.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Zero disabled lanes ahead of the first adder level.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      lane[i] = lane_en[i] ? in_data[i] : '0;
    end
  end

  // Derive first/last for the incoming beat. The first beat of a group uses
  // the live mode/len; later beats use the values latched on that first beat.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no
    // latch is inferred.
    beat_first = (cnt == '0);
    eff_mode   = beat_first ? acc_mode : mode_q;
    eff_len    = len_q;
    if (beat_first) begin
      eff_len = (acc_len == '0) ? CNT_W'(1) : acc_len;
    end
    beat_last        = !eff_mode || (cnt == eff_len - CNT_W'(1));
    head_flags.valid = in_valid;
    head_flags.first = beat_first;
    head_flags.last  = beat_last;
  end

  // Group counter and latched group parameters, stepped on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= 1'b0;
      len_q  <= '0;
    end else if (accept) begin
      if (beat_first) begin
        mode_q <= acc_mode;
        len_q  <= eff_len;
      end
      cnt <= beat_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Reduction tree: level k holds N_IN/2^k sums of width IN_W+k.
  for (genvar k = 1; k <= S; k++) begin : g_stage
    logic signed [IN_W+k-1:0] data [(N_IN>>k)-1:0];
    stage_flags_t             flags;

    if (k == 1) begin : g_head
      adder_tree_stage #(
        .N_IN (N_IN),
        .IN_W (IN_W)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .flags_in  (head_flags),
        .data_in   (lane),
        .flags_out (flags),
        .data_out  (data)
      );
    end else begin : g_body
      adder_tree_stage #(
        .N_IN (N_IN >> (k - 1)),
        .IN_W (IN_W + k - 1)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .flags_in  (g_stage[k-1].flags),
        .data_in   (g_stage[k-1].data),
        .flags_out (flags),
        .data_out  (data)
      );
    end

    if (k == S) begin : g_tail
      assign sum        = data[0];
      assign tail_flags = flags;
    end
  end

  assign sum_ext = {{CNT_W{sum[SUM_W-1]}}, sum};

  // Accumulator: a first beat loads, later beats add; only a last beat
  // raises out_valid, which then holds until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
    end else if (adv) begin
      if (tail_flags.valid) begin
        acc       <= tail_flags.first ? sum_ext : acc + sum_ext;
        out_valid <= tail_flags.last;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ADDER_TREE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp the accumulator into the signed OUT_W range.
  always_comb begin
    out_data = acc[OUT_W-1:0];
    out_sat  = 1'b0;
    if (acc > SAT_MAX) begin
      out_data = SAT_MAX[OUT_W-1:0];
      out_sat  = 1'b1;
    end else if (acc < SAT_MIN) begin
      out_data = SAT_MIN[OUT_W-1:0];
      out_sat  = 1'b1;
    end
  end
`else
  // Plain truncation with two's-complement wrap.
  assign out_data = acc[OUT_W-1:0];
  assign out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed self-checking bench for adder_tree_acc at default parameters
// (32 lanes, 16-bit in/out, 8-bit accumulate length).
module tb_adder_tree_acc;

  localparam int N_IN  = 32;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int CNT_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data [N_IN-1:0];
  logic [N_IN-1:0]         lane_en;
  logic                    acc_mode;
  logic [CNT_W-1:0]        acc_len;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] q_data [$];
  logic             q_sat  [$];
  int               q_cyc  [$];

  adder_tree_acc #(
    .N_IN  (N_IN),
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lane_en   (lane_en),
    .acc_mode  (acc_mode),
    .acc_len   (acc_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      q_data.push_back(out_data);
      q_sat.push_back(out_sat);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_data.delete();
    q_sat.delete();
    q_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat (value broadcast to all lanes) until accepted.
  // acc_cyc is the cycle index of the negedge on which it was seen accepted.
  task automatic send(input int v, input logic [N_IN-1:0] en, input logic mode,
                      input logic [CNT_W-1:0] len, output int acc_cyc);
    bit done;
    done    = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < N_IN; i++) in_data[i] = IN_W'(v);
    lane_en  = en;
    acc_mode = mode;
    acc_len  = len;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc_cyc = cyc;
        done    = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0d not accepted within 100 cycles", v);
    end
  endtask

  task automatic wait_outputs(input int n);
    int t;
    t = 0;
    while (q_data.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (q_data.size() < n) begin
      errors++;
      $display("FAIL wait_outputs: got %0d results, required %0d", q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_mode  = 1'b0;
    acc_len   = '0;
    lane_en   = '0;
    for (int i = 0; i < N_IN; i++) in_data[i] = '0;
    idle(3);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (out_data !== 16'sd0) begin
      errors++; $display("FAIL reset_out_data: got %h, required 0000", out_data);
    end
    checks++;
    if (out_sat !== 1'b0) begin
      errors++; $display("FAIL reset_out_sat: got %b, required 0", out_sat);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_per_beat();
    int c;
    clear_q();
    send(1, '1, 1'b0, 8'd0, c);
    wait_outputs(1);
    idle(4);
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL per_beat_count: got %0d results, required 1", q_data.size());
    end
    checks++;
    if (q_data[0] !== 16'd32) begin
      errors++; $display("FAIL per_beat_sum: got %0d, required 32", q_data[0]);
    end
    checks++;
    if (q_cyc[0] - c != 6) begin
      errors++; $display("FAIL per_beat_latency: got %0d, required 6", q_cyc[0] - c);
    end
  endtask

  task automatic test_lane_mask();
    int c;
    clear_q();
    send(100, 32'h0000FFFF, 1'b0, 8'd0, c);
    send(100, 32'h00000000, 1'b0, 8'd0, c);
    wait_outputs(2);
    checks++;
    if (q_data[0] !== 16'd1600) begin
      errors++; $display("FAIL mask_half: got %0d, required 1600", q_data[0]);
    end
    checks++;
    if (q_data[1] !== 16'd0) begin
      errors++; $display("FAIL mask_none: got %0d, required 0", q_data[1]);
    end
  endtask

  task automatic test_accumulate();
    int c;
    // Four beats of 2 on every lane, grouped by four.
    clear_q();
    for (int b = 0; b < 4; b++) send(2, '1, 1'b1, 8'd4, c);
    wait_outputs(1);
    idle(8);
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL acc4_count: got %0d results, required 1", q_data.size());
    end
    checks++;
    if (q_data[0] !== 16'd256) begin
      errors++; $display("FAIL acc4_sum: got %0d, required 256", q_data[0]);
    end
    checks++;
    if (q_cyc[0] - c != 6) begin
      errors++; $display("FAIL acc4_latency: got %0d, required 6", q_cyc[0] - c);
    end
    // acc_len = 0 in accumulate mode behaves as a per-beat sum.
    clear_q();
    send(3, '1, 1'b1, 8'd0, c);
    send(5, '1, 1'b1, 8'd0, c);
    wait_outputs(2);
    idle(4);
    checks++;
    if (q_data.size() != 2) begin
      errors++; $display("FAIL len0_count: got %0d results, required 2", q_data.size());
    end
    checks++;
    if (q_data[0] !== 16'd96 || q_data[1] !== 16'd160) begin
      errors++; $display("FAIL len0_sums: got %0d,%0d, required 96,160", q_data[0], q_data[1]);
    end
    // Mode/len changes inside a group are ignored.
    clear_q();
    send(1, '1, 1'b1, 8'd3, c);
    send(1, '1, 1'b0, 8'd1, c);
    send(1, '1, 1'b0, 8'd1, c);
    wait_outputs(1);
    idle(8);
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 16'd96) begin
      errors++; $display("FAIL midgroup_change: got %0d results first %0d, required 1 result 96",
                         q_data.size(), q_data[0]);
    end
  endtask

  task automatic test_saturation();
    int c;
    clear_q();
    send(32767, '1, 1'b0, 8'd0, c);
    send(-32768, '1, 1'b0, 8'd0, c);
    wait_outputs(2);
`ifdef ADDER_TREE_SAT_EN
    checks++;
    if (q_data[0] !== 16'h7FFF || q_sat[0] !== 1'b1) begin
      errors++; $display("FAIL sat_pos: got %h sat %b, required 7fff sat 1", q_data[0], q_sat[0]);
    end
    checks++;
    if (q_data[1] !== 16'h8000 || q_sat[1] !== 1'b1) begin
      errors++; $display("FAIL sat_neg: got %h sat %b, required 8000 sat 1", q_data[1], q_sat[1]);
    end
`else
    checks++;
    if (q_data[0] !== 16'hFFE0 || q_sat[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_pos: got %h sat %b, required ffe0 sat 0", q_data[0], q_sat[0]);
    end
    checks++;
    if (q_data[1] !== 16'h0000 || q_sat[1] !== 1'b0) begin
      errors++; $display("FAIL wrap_neg: got %h sat %b, required 0000 sat 0", q_data[1], q_sat[1]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int               c;
    logic [OUT_W-1:0] held;
    clear_q();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i, '1, 1'b0, 8'd0, c);
      end
      begin
        idle(8);
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_out_valid: got %b, required 1", out_valid);
        end
        held = out_data;
        repeat (2) @(negedge clk);
        checks++;
        if (out_data !== held || out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_hold: got %0d valid %b, required %0d valid 1",
                             out_data, out_valid, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_outputs(10);
    idle(8);
    checks++;
    if (q_data.size() != 10) begin
      errors++; $display("FAIL stream_count: got %0d results, required 10", q_data.size());
    end
    for (int i = 0; i < 10 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== OUT_W'(32 * i)) begin
        errors++; $display("FAIL stream_data[%0d]: got %0d, required %0d", i, q_data[i], 32 * i);
      end
    end
  endtask

  task automatic test_reset_mid_group();
    int c;
    clear_q();
    send(1, '1, 1'b1, 8'd4, c);
    send(1, '1, 1'b1, 8'd4, c);
    idle(8);
    checks++;
    if (q_data.size() != 0 || out_data !== 16'sd64) begin
      errors++; $display("FAIL partial_group: got %0d results acc %0d, required 0 results acc 64",
                         q_data.size(), out_data);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0) begin
      errors++; $display("FAIL midgroup_reset: got valid %b data %0d, required valid 0 data 0",
                         out_valid, out_data);
    end
    for (int b = 0; b < 4; b++) send(1, '1, 1'b1, 8'd4, c);
    wait_outputs(1);
    idle(8);
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 16'd128) begin
      errors++; $display("FAIL post_reset_group: got %0d results first %0d, required 1 result 128",
                         q_data.size(), q_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_per_beat();
    test_lane_mask();
    test_accumulate();
    test_saturation();
    test_back_to_back();
    test_reset_mid_group();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
